// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with helper module alu)
// Purpose  : Two-requester round-robin front end for one shared ALU. A
//            requester is granted in IDLE, its operands are latched, the ALU
//            result is registered in EXEC, and the result is held in RESP
//            until the owning requester takes it.
// Ports    : clk, reset                  - clock, synchronous active-high reset
//            reqX_valid/ready            - request handshake, X = 0/1
//            reqX_a/b/op                 - operands and opcode of requester X
//            respX_valid/ready           - response handshake, X = 0/1
//            resp_result, resp_carry     - shared registered result and carry
//            busy                        - high whenever the FSM is not IDLE
//            ops_done                    - completed response handshakes (wraps)
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// alu: purely combinational. op 00 add, 01 sub (a-b), 10 and, 11 or.
// Carry: add -> carry out of MSB; sub -> 1 when a >= b (no borrow); logic -> 0.
// ----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    y     = '0;
    carry = 1'b0;
    case (op)
      2'b00: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      2'b01: begin
        y     = a - b;
        carry = (a >= b);
      end
      2'b10:   y = a & b;
      default: y = a | b;
    endcase
  end

endmodule

// ----------------------------------------------------------------------------
// alu_arbiter: top level
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             busy,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] a_q,          a_d;
  logic [WIDTH-1:0] b_q,          b_d;
  logic [1:0]       op_q,         op_d;
  logic             owner_q,      owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic             carry_q,      carry_d;
  logic [15:0]      ops_done_q,   ops_done_d;

  logic             grant_id;
  logic             accept;
  logic             owner_ready;
  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;

  // The ALU only ever sees the latched operands, so requesters are free to
  // change their inputs once they have been accepted.
  alu #(.WIDTH(WIDTH)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .carry (alu_carry)
  );

  always_comb begin
    // Round robin: with both pending, favour the one not granted last time.
    // With a single requester, req1_valid alone selects requester 1.
    if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    else                          grant_id = req1_valid;

    // Reset gates acceptance so ready never rises while reset is asserted.
    accept      = (state_q == IDLE) && (req0_valid || req1_valid) && !reset;
    req0_ready  = accept && !grant_id;
    req1_ready  = accept &&  grant_id;

    // Only the owner's response ready can complete the transaction.
    owner_ready = owner_q ? resp1_ready : resp0_ready;

    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    carry_d      = carry_q;
    ops_done_d   = ops_done_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = grant_id ? req1_a  : req0_a;
          b_d          = grant_id ? req1_b  : req0_b;
          op_d         = grant_id ? req1_op : req0_op;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_y;
        carry_d  = alu_carry;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 2'b00;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      result_q     <= '0;
      carry_q      <= 1'b0;
      ops_done_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) &&  owner_q;
  assign resp_result = result_q;
  assign resp_carry  = carry_q;
  assign busy        = (state_q != IDLE);
  assign ops_done    = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [7:0] resp_result;
  logic       resp_carry, busy;
  logic [15:0] ops_done;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ops;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_result (resp_result),
    .resp_carry  (resp_carry),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from a single requester; starts and ends in IDLE.
  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] er, input logic ec);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    chk("accept_ready0", {31'd0, req0_ready}, {31'd0, !id});
    chk("accept_ready1", {31'd0, req1_ready}, {31'd0, id});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("exec_busy",   {31'd0, busy}, 32'd1);
    chk("exec_resp",   {30'd0, resp1_valid, resp0_valid}, 32'd0);
    tick();
    chk("resp_valid",  {30'd0, resp1_valid, resp0_valid}, id ? 32'd2 : 32'd1);
    chk("resp_result", {24'd0, resp_result}, {24'd0, er});
    chk("resp_carry",  {31'd0, resp_carry}, {31'd0, ec});
    if (id) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    exp_ops = exp_ops + 16'd1;
    chk("done_busy",     {31'd0, busy}, 32'd0);
    chk("done_ops",      {16'd0, ops_done}, {16'd0, exp_ops});
    chk("done_respidle", {30'd0, resp1_valid, resp0_valid}, 32'd0);
  endtask

  // Both requesters held valid throughout; checks who gets the grant.
  task automatic serve_both(input logic exp_id);
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h02; req1_op = 2'b00;
    #1;
    chk("rr_ready", {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
    tick();
    tick();
    chk("rr_owner",  {30'd0, resp1_valid, resp0_valid}, exp_id ? 32'd2 : 32'd1);
    chk("rr_result", {24'd0, resp_result}, exp_id ? 32'h22 : 32'h11);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    exp_ops = exp_ops + 16'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_ops = 16'd0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    exp_ops = 16'd0;
    tick();
    tick();

    // Reset state, with a request pending while reset is still high.
    req0_valid = 1'b1;
    #1;
    chk("rst_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_resp",   {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("rst_result", {24'd0, resp_result}, 32'd0);
    chk("rst_carry",  {31'd0, resp_carry}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_ops",    {16'd0, ops_done}, 32'd0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    // ALU function and carry rules.
    do_op(1'b0, 8'hBD, 8'hA5, 2'b00, 8'h62, 1'b1);
    do_op(1'b1, 8'hBD, 8'hA5, 2'b01, 8'h18, 1'b1);
    do_op(1'b1, 8'h05, 8'h07, 2'b01, 8'hFE, 1'b0);
    do_op(1'b1, 8'h07, 8'h07, 2'b01, 8'h00, 1'b1);
    do_op(1'b0, 8'hBD, 8'hA5, 2'b10, 8'hA5, 1'b0);
    do_op(1'b0, 8'hBD, 8'hA5, 2'b11, 8'hBD, 1'b0);
    do_op(1'b0, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1);
    // Single requester granted even though it was granted last time.
    do_op(1'b0, 8'h01, 8'h02, 2'b00, 8'h03, 1'b0);

    // Round robin after reset: 0 first, then alternating.
    do_reset();
    serve_both(1'b0);
    serve_both(1'b1);
    serve_both(1'b0);
    serve_both(1'b1);
    serve_both(1'b0);
    serve_both(1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_ops", {16'd0, ops_done}, {16'd0, exp_ops});

    // Response back-pressure; non-owner resp_ready has no effect.
    req0_valid = 1'b1; req0_a = 8'hBD; req0_b = 8'hA5; req0_op = 2'b00;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid  = 1'b1;
    resp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid",  {30'd0, resp1_valid, resp0_valid}, 32'd1);
      chk("bp_result", {24'd0, resp_result}, 32'h62);
      chk("bp_carry",  {31'd0, resp_carry}, 32'd1);
      chk("bp_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("bp_busy",   {31'd0, busy}, 32'd1);
      chk("bp_ops",    {16'd0, ops_done}, {16'd0, exp_ops});
      tick();
    end
    resp1_ready = 1'b0;
    req1_valid  = 1'b0;
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    exp_ops = exp_ops + 16'd1;
    chk("bp_done_ops",  {16'd0, ops_done}, {16'd0, exp_ops});
    chk("bp_done_busy", {31'd0, busy}, 32'd0);

    // Reset during EXEC discards the operation; pending requester re-served.
    do_reset();
    tick();
    req1_valid = 1'b1; req1_a = 8'h30; req1_b = 8'h04; req1_op = 2'b01;
    tick();
    chk("rx_exec_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("rx_busy",   {31'd0, busy}, 32'd0);
    chk("rx_resp",   {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("rx_ops",    {16'd0, ops_done}, 32'd0);
    chk("rx_result", {24'd0, resp_result}, 32'd0);
    chk("rx_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    chk("rx_resp2",  {30'd0, resp1_valid, resp0_valid}, 32'd0);
    reset = 1'b0;
    exp_ops = 16'd0;
    do_op(1'b1, 8'h30, 8'h04, 2'b01, 8'h2C, 1'b1);

    // ops_done wrap: preload near the top, then complete real handshakes.
    force dut.ops_done_q = 16'hFFFE;
    tick();
    release dut.ops_done_q;
    tick();
    exp_ops = 16'hFFFE;
    chk("wrap_preload", {16'd0, ops_done}, 32'h0000FFFE);
    do_op(1'b0, 8'h01, 8'h01, 2'b00, 8'h02, 1'b0);
    chk("wrap_ffff", {16'd0, ops_done}, 32'h0000FFFF);
    do_op(1'b1, 8'h01, 8'h01, 2'b00, 8'h02, 1'b0);
    chk("wrap_zero", {16'd0, ops_done}, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid, req1_valid  in  1  requester x has an operation pending.
REQ-005 req0_ready, req1_ready  out  1  arbiter accepts requester x this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands of requester x.
REQ-007 req0_op, req1_op  in  2  opcode: 00 add, 01 sub (a-b), 10 and, 11 or.
REQ-008 resp0_valid, resp1_valid  out  1  result for requester x available.
REQ-009 resp0_ready, resp1_ready  in  1  requester x takes the result.
REQ-010 resp_result  out  WIDTH  registered result, shared by both requesters.
REQ-011 resp_carry  out  1  registered carry, shared by both requesters.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 ops_done  out  16  count of completed response handshakes.

Function
REQ-014 The block SHALL contain exactly one alu #(WIDTH) instance, driven only from internal operand/opcode registers.
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-016 IDLE: if any reqx_valid, grant one requester; reqx_ready for the granted requester SHALL be high combinationally in that cycle; all other ready outputs low.
REQ-017 reqx_ready SHALL be low in EXEC and RESP; requesters hold valid and operands until ready.
REQ-018 On acceptance (valid & ready), the block SHALL latch a, b, op and owner ID, and go to EXEC.
REQ-019 EXEC (exactly one cycle): the block SHALL register alu result into resp_result and carry into resp_carry, then go to RESP.
REQ-020 Carry rule: add -> carry out of MSB; sub -> 1 when a >= b unsigned (no borrow), else 0; and/or -> 0.
REQ-021 RESP: respx_valid SHALL be high only for the owner; resp_result/resp_carry SHALL stay stable until respx_ready is high.
REQ-022 RESP with owner's respx_ready high SHALL return to IDLE next cycle and increment ops_done by 1; ops_done SHALL wrap 0xFFFF -> 0x0000.
REQ-023 Non-owner resp_ready SHALL be ignored.
REQ-024 Latency: accept in cycle C -> EXEC in C+1 -> respx_valid high from C+2; next acceptance no earlier than C+3 (handshake in C+2).
REQ-025 Arbitration: round-robin via 1-bit last_grant register; on both valid in IDLE, grant the requester != last_grant; single valid is granted regardless.
REQ-026 last_grant SHALL update only on acceptance.
REQ-027 Width rule: add/sub SHALL be modulo 2^WIDTH; no sign extension.

Reset
REQ-028 reset high at a rising edge SHALL, from any state, force IDLE and discard in-flight operation with no response.
REQ-029 After reset: req*_ready 0 until next IDLE evaluation, resp*_valid 0, resp_result 0, resp_carry 0, busy 0, ops_done 0, last_grant 1 (requester 0 has priority first).
REQ-030 reqx_ready SHALL be low while reset is high.

Verification
REQ-031 req0 add a=0xBD b=0xA5 -> resp0_valid two cycles after acceptance, resp_result 0x62, resp_carry 1, ops_done 1.
REQ-032 req1 sub a=0xBD b=0xA5 -> 0x18 carry 1; then sub a=0x05 b=0x07 -> 0xFE carry 0; and 0xBD,0xA5 -> 0xA5 carry 0; or -> 0xBD carry 0.
REQ-033 After reset, req0 and req1 valid in same cycle -> req0 served first, req1 second; both held valid again -> order alternates 0,1,0,1.
REQ-034 resp0_ready held low 4 cycles in RESP -> resp0_valid stays high, result stable, both req*_ready low, busy high; resp1_ready high meanwhile has no effect.
REQ-035 reset asserted during EXEC -> next cycle IDLE, no resp*_valid, ops_done 0, pending requester re-served afterwards.
REQ-036 Preload via 65535 completed ops -> ops_done 0xFFFF; one more handshake -> 0x0000.
